// File: rtl/alu_pkg.sv
// Shared flag/condition definitions for the add/sub result path and branch unit.
package alu_pkg;

    localparam int FLG_OF = 0;
    localparam int FLG_CF = 1;
    localparam int FLG_ZF = 2;
    localparam int FLG_NF = 3;
    localparam int NFLG   = 4;

    localparam int COND_EQ  = 0;
    localparam int COND_LT  = 1;
    localparam int COND_GE  = 2;
    localparam int COND_GT  = 3;
    localparam int COND_LTU = 4;
    localparam int COND_GTU = 5;
    localparam int NCOND    = 6;

    // Conditions assume the flags came from a subtract a-b.
    function automatic logic [NCOND-1:0] decode_cond(input logic [NFLG-1:0] flags);
        logic lt;
        logic [NCOND-1:0] c;
        c           = '0;
        lt          = flags[FLG_NF] ^ flags[FLG_OF];
        c[COND_EQ]  = flags[FLG_ZF];
        c[COND_LT]  = lt;
        c[COND_GE]  = ~lt;
        c[COND_GT]  = ~flags[FLG_ZF] & ~lt;
        c[COND_LTU] = ~flags[FLG_CF];
        c[COND_GTU] = flags[FLG_CF] & ~flags[FLG_ZF];
        return c;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer: registered head plus one parking entry.
module alu_skid_buf #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] head_q;
    logic [W-1:0] skid_q;
    logic         head_v;
    logic         skid_v;
    logic         accept;
    logic         retire;

    assign accept    = in_valid & in_ready;
    assign retire    = head_v & out_ready;
    assign in_ready  = ~skid_v;
    assign out_valid = head_v;
    assign out_data  = head_q;

    // The skid entry only fills while the head is stalled, so it is never
    // occupied with an empty head; head refills prefer it to keep order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (~head_v | retire) begin
            if (skid_v) begin
                head_q <= skid_q;
                head_v <= 1'b1;
                skid_v <= 1'b0;
            end else if (accept) begin
                head_q <= in_data;
                head_v <= 1'b1;
            end else begin
                head_v <= 1'b0;
            end
        end else if (accept) begin
            skid_q <= in_data;
            skid_v <= 1'b1;
        end
    end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered add/sub result stage: skid-buffered result+flags, compare decode,
// sticky overflow and saturating accepted-operation counter.
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_result,
    input  logic             in_of,
    input  logic             in_cf,
    input  logic             in_zf,
    input  logic             in_nf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [3:0]       out_flags,
    output logic [5:0]       out_cond,
    output logic             sticky_of,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [W+3:0] in_data;
    logic [W+3:0] head;
    logic         accept;

    assign in_data = {in_nf, in_zf, in_cf, in_of, in_result};
    assign accept  = in_valid & in_ready;

    alu_skid_buf #(
        .W(W + 4)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_result = head[W-1:0];
    assign out_flags  = head[W+3:W];
    assign out_cond   = out_valid ? decode_cond(out_flags) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_of <= 1'b0;
            op_count  <= '0;
        end else begin
            sticky_of <= (sticky_of & ~sticky_clr) | (accept & in_of);
            if (accept && op_count != CNT_MAX)
                op_count <= op_count + 1'b1;
        end
    end

endmodule
